// File: rtl/dmadd_sequencer.sv
// dmadd_sequencer: command FIFO plus job sequencer for the delta multiply-add
// engine. Beats {last, op, index, data} are buffered. Each complete job is
// then driven through the engine phases in order: clear, init, load, run,
// capture. The captured result is held on a valid/ready port.
// Optional build macro DMSEQ_OPCHECK_EN: beats whose op differs from the
// job's first op are dropped (not loaded) and flag res_err for that job.
module dmadd_sequencer #(
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_data,
    input  logic        cmd_last,
    output logic        dm_rst_n,
    output logic [1:0]  dm_insn,
    output logic        dm_load,
    output logic        dm_run,
    output logic [3:0]  dm_index,
    output logic [3:0]  dm_data,
    input  logic [12:0] dm_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [12:0] res_data,
    output logic        res_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, INIT, LOAD, RUN, CAPTURE, RESULT
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, jobs_q, jobs_d;
    logic [1:0]      job_op_q, job_op_d;
    logic [7:0]      run_cnt_q, run_cnt_d;
    logic            err_q, err_d;
    logic [12:0]     res_data_q, res_data_d;
    logic            dm_rst_n_q, dm_rst_n_d;
    logic [1:0]      dm_insn_q, dm_insn_d;
    logic            dm_load_q, dm_load_d;
    logic            dm_run_q, dm_run_d;
    logic [3:0]      dm_index_q, dm_index_d;
    logic [3:0]      dm_data_q, dm_data_d;

    logic        full, push, pop, push_last, pop_last;
    logic [10:0] head;

    assign full      = (count_q == CW'(DEPTH));
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == LOAD);
    assign head      = mem_q[rd_ptr_q];
    assign push_last = push && cmd_last;
    assign pop_last  = pop && head[10];

    // FIFO storage; emptiness is tracked by pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_last, cmd_data};
    end

    // FIFO pointers, occupancy and complete-job count
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        jobs_d = jobs_q;
        unique case ({push_last, pop_last})
            2'b10:   jobs_d = jobs_q + CW'(1);
            2'b01:   jobs_d = jobs_q - CW'(1);
            default: jobs_d = jobs_q;
        endcase
    end

    // Job phase sequencing, run-length count, error flag and result capture
    always_comb begin
        state_d    = state_q;
        job_op_d   = job_op_q;
        run_cnt_d  = run_cnt_q;
        err_d      = err_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (jobs_q != '0) begin
                    state_d  = CLEAR;
                    job_op_d = head[9:8];
                end
            end
            CLEAR: begin
                state_d = INIT;
                err_d   = 1'b0;
            end
            INIT: state_d = LOAD;
            LOAD: begin
`ifdef DMSEQ_OPCHECK_EN
                if (head[9:8] != job_op_q) err_d = 1'b1;
`endif
                if (head[10]) begin
                    state_d   = RUN;
                    run_cnt_d = 8'd0;
                end
            end
            RUN: begin
                if (run_cnt_q == 8'(RUN_CYCLES - 1)) state_d = CAPTURE;
                else run_cnt_d = run_cnt_q + 8'd1;
            end
            CAPTURE: begin
                res_data_d = dm_out;
                state_d    = RESULT;
            end
            RESULT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine drives are registered from the next state, so each output lines
    // up with the cycle its phase occupies. In LOAD the entry at rd_ptr_d is
    // the one popped during the following cycle.
    always_comb begin
        dm_rst_n_d = (state_d != CLEAR);
        dm_run_d   = (state_d == RUN);
        dm_insn_d  = dm_insn_q;
        if (state_d inside {INIT, LOAD, RUN, CAPTURE}) dm_insn_d = job_op_d;
        dm_load_d  = 1'b0;
        dm_index_d = dm_index_q;
        dm_data_d  = dm_data_q;
        if (state_d == LOAD) begin
            dm_index_d = mem_q[rd_ptr_d][7:4];
            dm_data_d  = mem_q[rd_ptr_d][3:0];
`ifdef DMSEQ_OPCHECK_EN
            dm_load_d  = (mem_q[rd_ptr_d][9:8] == job_op_d);
`else
            dm_load_d  = 1'b1;
`endif
        end
    end

    // State register; reset discards FIFO contents and any partial job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            jobs_q     <= '0;
            job_op_q   <= 2'd0;
            run_cnt_q  <= 8'd0;
            err_q      <= 1'b0;
            res_data_q <= 13'd0;
            dm_rst_n_q <= 1'b0;
            dm_insn_q  <= 2'd0;
            dm_load_q  <= 1'b0;
            dm_run_q   <= 1'b0;
            dm_index_q <= 4'd0;
            dm_data_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            jobs_q     <= jobs_d;
            job_op_q   <= job_op_d;
            run_cnt_q  <= run_cnt_d;
            err_q      <= err_d;
            res_data_q <= res_data_d;
            dm_rst_n_q <= dm_rst_n_d;
            dm_insn_q  <= dm_insn_d;
            dm_load_q  <= dm_load_d;
            dm_run_q   <= dm_run_d;
            dm_index_q <= dm_index_d;
            dm_data_q  <= dm_data_d;
        end
    end

    assign cmd_ready = !full;
    assign dm_rst_n  = dm_rst_n_q;
    assign dm_insn   = dm_insn_q;
    assign dm_load   = dm_load_q;
    assign dm_run    = dm_run_q;
    assign dm_index  = dm_index_q;
    assign dm_data   = dm_data_q;
    assign res_valid = (state_q == RESULT);
    assign res_data  = res_data_q;
    assign res_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
